entry_alloc: RTL and testbench



---
 rtl/entry_alloc_pkg.sv | 8 +
 rtl/entry_alloc_prio_search.sv | 26 ++
 rtl/entry_alloc.sv | 72 +++++++
 tb/tb_entry_alloc.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/entry_alloc_pkg.sv
// Default pool geometry for the entry allocator, shared with requesters that
// size their tag fields from it.
package entry_alloc_pkg;

  localparam int ENTSEL_DEF = 2;
  localparam int ENTNUM_DEF = 4;

endpackage

// File: rtl/entry_alloc_prio_search.sv
// Lowest-index set-bit search: combinational, returns index and an enable.
// The index is 0 whenever no bit is set.
module prio_search
  import entry_alloc_pkg::*;
#(
  parameter int W  = ENTNUM_DEF,
  parameter int IW = ENTSEL_DEF
) (
  input  logic [W-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          en
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    idx = '0;
    en  = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
        en  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/entry_alloc.sv
// Entry allocator: registered busy vector and occupancy count, lowest-free
// grant via prio_search, and a release port with illegal-free detection.
module entry_alloc
  import entry_alloc_pkg::*;
#(
  parameter int ENTSEL = ENTSEL_DEF,
  parameter int ENTNUM = ENTNUM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_vld,
  output logic [ENTSEL-1:0] alloc_idx,
  input  logic              free_vld,
  input  logic [ENTSEL-1:0] free_idx,
  output logic [ENTNUM-1:0] busy,
  output logic [ENTSEL:0]   count,
  output logic              full,
  output logic              empty,
  output logic              err_free
);

  localparam int              PAD      = 1 << ENTSEL;
  localparam logic [ENTSEL:0] FULL_CNT = (ENTSEL + 1)'(ENTNUM);
  localparam logic [ENTSEL:0] CNT_ONE  = (ENTSEL + 1)'(1);

  logic              fire;
  logic              free_legal;
  logic [PAD-1:0]    busy_ext;
  logic [PAD-1:0]    set_ext;
  logic [PAD-1:0]    clr_ext;
  logic [ENTNUM-1:0] busy_nxt;

  prio_search #(
    .W  (ENTNUM),
    .IW (ENTSEL)
  ) u_search (
    .req (~busy),
    .idx (alloc_idx),
    .en  (alloc_vld)
  );

  // Indices at or above ENTNUM read as not-busy through the padded copy, so a
  // single bit lookup covers both the range check and the busy check.
  assign busy_ext   = PAD'(busy);
  assign free_legal = free_vld && busy_ext[free_idx];
  assign fire       = alloc_req && alloc_vld;

  assign set_ext  = fire       ? (PAD'(1) << alloc_idx) : '0;
  assign clr_ext  = free_legal ? (PAD'(1) << free_idx)  : '0;
  assign busy_nxt = (busy | set_ext[ENTNUM-1:0]) & ~clr_ext[ENTNUM-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      count    <= '0;
      err_free <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      err_free <= free_vld && !free_legal;
      case ({fire, free_legal})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: tb/tb_entry_alloc.sv
// Self-checking bench for entry_alloc: directed scenarios plus a randomized
// run against an array-based reference model of the pool.
module tb_entry_alloc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       alloc_req = 1'b0;
  logic       alloc_vld;
  logic [1:0] alloc_idx;
  logic       free_vld = 1'b0;
  logic [1:0] free_idx = 2'd0;
  logic [3:0] busy;
  logic [2:0] count;
  logic       full, empty, err_free;

  logic       alloc_req3 = 1'b0;
  logic       alloc_vld3;
  logic [1:0] alloc_idx3;
  logic       free_vld3 = 1'b0;
  logic [1:0] free_idx3 = 2'd0;
  logic [2:0] busy3;
  logic [2:0] count3;
  logic       full3, empty3, err_free3;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one flag per slot, plus the pending error pulse.
  bit m_busy [4];
  bit m_err;

  always #5 clk = ~clk;

  entry_alloc #(.ENTSEL(2), .ENTNUM(4)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_vld(alloc_vld), .alloc_idx(alloc_idx),
    .free_vld(free_vld), .free_idx(free_idx),
    .busy(busy), .count(count), .full(full), .empty(empty), .err_free(err_free)
  );

  entry_alloc #(.ENTSEL(2), .ENTNUM(3)) dut3 (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req3), .alloc_vld(alloc_vld3), .alloc_idx(alloc_idx3),
    .free_vld(free_vld3), .free_idx(free_idx3),
    .busy(busy3), .count(count3), .full(full3), .empty(empty3), .err_free(err_free3)
  );

  function automatic logic [3:0] model_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic int model_lowest_free();
    for (int i = 0; i < 4; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_busy[i] = 1'b0;
    m_err = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the model, return at posedge+1.
  task automatic step(input bit req, input bit fv, input logic [1:0] fidx);
    int  lf;
    bit  legal;
    alloc_req = req;
    free_vld  = fv;
    free_idx  = fidx;
    lf    = model_lowest_free();
    legal = fv && m_busy[fidx];
    @(posedge clk);
    #1;
    if (req && lf >= 0) m_busy[lf] = 1'b1;
    if (legal) m_busy[fidx] = 1'b0;
    m_err = fv && !legal;
    alloc_req = 1'b0;
    free_vld  = 1'b0;
    free_idx  = 2'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({busy, count, full, empty, err_free, alloc_vld, alloc_idx} !== {4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b count=%0d full=%b empty=%b err=%b vld=%b idx=%0d, want busy=0000 count=0 full=0 empty=1 err=0 vld=1 idx=0",
               busy, count, full, empty, err_free, alloc_vld, alloc_idx);
    end
    do_reset();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (alloc_vld !== 1'b1 || alloc_idx !== 2'(i)) begin
        n_bad++;
        $display("FAIL fill_grant%0d: vld=%b idx=%0d, want vld=1 idx=%0d", i, alloc_vld, alloc_idx, i);
      end
      step(1'b1, 1'b0, 2'd0);
    end
    n_cmp++;
    if ({busy, count, full, empty, alloc_vld, alloc_idx} !== {4'b1111, 3'd4, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      n_bad++;
      $display("FAIL fill_full: busy=%b count=%0d full=%b empty=%b vld=%b idx=%0d, want 1111 4 1 0 0 0",
               busy, count, full, empty, alloc_vld, alloc_idx);
    end
    step(1'b1, 1'b0, 2'd0);
    n_cmp++;
    if ({busy, count, err_free} !== {4'b1111, 3'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL req_when_full: busy=%b count=%0d err=%b, want 1111 4 0", busy, count, err_free);
    end
  endtask

  task automatic test_free_full();
    step(1'b0, 1'b1, 2'd2);
    n_cmp++;
    if ({busy, alloc_vld, alloc_idx, count, full, err_free} !== {4'b1011, 1'b1, 2'd2, 3'd3, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL free_from_full: busy=%b vld=%b idx=%0d count=%0d full=%b err=%b, want 1011 1 2 3 0 0",
               busy, alloc_vld, alloc_idx, count, full, err_free);
    end
  endtask

  task automatic test_simul();
    step(1'b0, 1'b1, 2'd3);
    step(1'b1, 1'b0, 2'd0);
    n_cmp++;
    if ({busy, alloc_idx, count} !== {4'b0111, 2'd3, 3'd3}) begin
      n_bad++;
      $display("FAIL simul_setup: busy=%b idx=%0d count=%0d, want 0111 3 3", busy, alloc_idx, count);
    end
    step(1'b1, 1'b1, 2'd1);
    n_cmp++;
    if ({busy, count, alloc_idx, err_free} !== {4'b1101, 3'd3, 2'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL simul_alloc_free: busy=%b count=%0d idx=%0d err=%b, want 1101 3 1 0",
               busy, count, alloc_idx, err_free);
    end
  endtask

  task automatic test_illegal_free();
    do_reset();
    step(1'b0, 1'b1, 2'd0);
    n_cmp++;
    if ({err_free, busy, count, empty} !== {1'b1, 4'b0000, 3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL illegal_free_pulse: err=%b busy=%b count=%0d empty=%b, want 1 0000 0 1",
               err_free, busy, count, empty);
    end
    step(1'b0, 1'b0, 2'd0);
    n_cmp++;
    if (err_free !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_free_one_cycle: err=%b, want 0", err_free);
    end
  endtask

  task automatic test_ent3();
    do_reset();
    alloc_req3 = 1'b1;
    @(posedge clk); #1;
    alloc_req3 = 1'b0;
    free_vld3 = 1'b1; free_idx3 = 2'd3;
    @(posedge clk); #1;
    free_vld3 = 1'b0; free_idx3 = 2'd0;
    n_cmp++;
    if ({err_free3, busy3, count3} !== {1'b1, 3'b001, 3'd1}) begin
      n_bad++;
      $display("FAIL ent3_out_of_range: err=%b busy=%b count=%0d, want 1 001 1", err_free3, busy3, count3);
    end
    alloc_req3 = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (err_free3 !== 1'b0) begin
      n_bad++;
      $display("FAIL ent3_pulse_width: err=%b, want 0", err_free3);
    end
    @(posedge clk); #1;
    alloc_req3 = 1'b0;
    n_cmp++;
    if ({busy3, count3, full3, alloc_vld3, alloc_idx3} !== {3'b111, 3'd3, 1'b1, 1'b0, 2'd0}) begin
      n_bad++;
      $display("FAIL ent3_full: busy=%b count=%0d full=%b vld=%b idx=%0d, want 111 3 1 0 0",
               busy3, count3, full3, alloc_vld3, alloc_idx3);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b1, 2'd2);
    n_cmp++;
    if (busy !== 4'b1010) begin
      n_bad++;
      $display("FAIL async_setup: busy=%b, want 1010", busy);
    end
    alloc_req = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, count, empty, full, alloc_vld, alloc_idx} !== {4'b0000, 3'd0, 1'b1, 1'b0, 1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL async_reset: busy=%b count=%0d empty=%b full=%b vld=%b idx=%0d, want 0000 0 1 0 1 0",
               busy, count, empty, full, alloc_vld, alloc_idx);
    end
    alloc_req = 1'b0;
    do_reset();
  endtask

  task automatic test_random();
    bit         req, fv;
    logic [1:0] fidx;
    int         lf;
    for (int n = 0; n < 400; n++) begin
      req  = ($urandom_range(0, 99) < 55);
      fv   = ($urandom_range(0, 99) < 45);
      fidx = 2'($urandom_range(0, 3));
      step(req, fv, fidx);
      lf = model_lowest_free();
      n_cmp++;
      if ({busy, count, full, empty, err_free, alloc_vld, alloc_idx} !==
          {model_vec(), 3'(model_cnt()), model_cnt() == 4, model_cnt() == 0, m_err,
           lf >= 0, (lf >= 0) ? 2'(lf) : 2'd0}) begin
        n_bad++;
        $display("FAIL random_%0d: busy=%b count=%0d full=%b empty=%b err=%b vld=%b idx=%0d, want busy=%b count=%0d err=%b lowest_free=%0d",
                 n, busy, count, full, empty, err_free, alloc_vld, alloc_idx,
                 model_vec(), model_cnt(), m_err, lf);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd0);
    n_cmp++;
    if ({busy, alloc_idx} !== {4'b0010, 2'd0}) begin
      n_bad++;
      $display("FAIL b2b_reuse: busy=%b idx=%0d, want 0010 0", busy, alloc_idx);
    end
    step(1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b0, 2'd0);
    n_cmp++;
    if ({busy, count, alloc_idx} !== {4'b0111, 3'd3, 2'd3}) begin
      n_bad++;
      $display("FAIL b2b_ascending: busy=%b count=%0d idx=%0d, want 0111 3 3", busy, count, alloc_idx);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fill();
    test_free_full();
    test_simul();
    test_illegal_free();
    test_ent3();
    test_async_reset();
    test_back_to_back();
    do_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1, "timeout");
  end

endmodule
